// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types for the DDR4 command port arbiter.
// State encoding, requester indices and the read-return tag.
package ddr_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int PORT_PCIE = 0;
    localparam int PORT_CORE = 1;
    localparam int PORT_ML   = 2;

    localparam int TAG_ID_W = 2;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder; first requester at or after the pointer.
// Pointer must be below N.
module rr_pick #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    int w_c;

    // Walk from the far end so the nearest requester overwrites the rest.
    always_comb begin
        o_idx = '0;
        o_any = |i_req;
        w_c   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_c = (int'(i_ptr) + k) % N;
            if (i_req[w_c]) o_idx = W'(w_c);
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: round-robin burst arbiter for the shared DDR4 command port.
// Define DDR_ARB_PCIE_PRIO_EN to give port 0 (PCIe) precedence at every decision.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int N_PORTS   = 3,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 1,
    localparam int OW       = $clog2(N_PORTS)
) (
    input  logic                        pcie_clk,
    input  logic                        pcie_rst,
    input  logic [N_PORTS-1:0]          m_req,
    input  logic [N_PORTS-1:0]          m_we,
    input  logic [N_PORTS-1:0]          m_last,
    input  logic [N_PORTS*DATA_W-1:0]   m_addr,
    input  logic [N_PORTS*DATA_W-1:0]   m_wdata,
    output logic [N_PORTS-1:0]          m_gnt,
    output logic [N_PORTS-1:0]          m_rvalid,
    output logic [DATA_W-1:0]           m_rdata,
    output logic [DATA_W-1:0]           ddr_addr,
    output logic [DATA_W-1:0]           ddr_data_in,
    output logic                        ddr_we,
    output logic                        ddr_re,
    input  logic [DATA_W-1:0]           ddr_data_out,
    input  logic                        ddr_ready,
    output logic [OW-1:0]               arb_owner,
    output logic                        arb_busy
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    arb_state_e    r_state;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_rr_ptr;
    logic [CW-1:0] r_beat_cnt;
    rd_tag_t       r_tag [RD_LAT];

    logic [OW-1:0] w_winner;
    logic          w_any;
    logic          w_issue;
    logic          w_accept;
    logic          w_end;
    logic [OW-1:0] w_next_ptr;

`ifdef DDR_ARB_PCIE_PRIO_EN
    localparam int SW = (N_PORTS > 2) ? $clog2(N_PORTS - 1) : 1;

    logic [SW-1:0] w_sub_ptr;
    logic [SW-1:0] w_sub_idx;
    logic          w_sub_any;

    // Ports 1..N-1 rotate among themselves; the sub-picker sees them shifted down by one.
    assign w_sub_ptr = (r_rr_ptr == '0) ? '0 : SW'(r_rr_ptr - OW'(1));

    rr_pick #(.N(N_PORTS - 1), .W(SW)) u_pick (
        .i_req (m_req[N_PORTS-1:1]),
        .i_ptr (w_sub_ptr),
        .o_idx (w_sub_idx),
        .o_any (w_sub_any)
    );

    assign w_any    = m_req[PORT_PCIE] | w_sub_any;
    assign w_winner = m_req[PORT_PCIE] ? OW'(PORT_PCIE)
                                       : OW'(w_sub_idx) + OW'(1);
`else
    rr_pick #(.N(N_PORTS), .W(OW)) u_pick (
        .i_req (m_req),
        .i_ptr (r_rr_ptr),
        .o_idx (w_winner),
        .o_any (w_any)
    );
`endif

    assign w_issue    = (r_state == BURST) && m_req[r_owner];
    assign w_accept   = w_issue && ddr_ready;
    assign w_end      = (r_state == BURST) &&
                        (!m_req[r_owner] ||
                         (w_accept && (m_last[r_owner] || r_beat_cnt == CNT_MAX)));
    assign w_next_ptr = (r_owner == OW'(N_PORTS - 1)) ? '0 : r_owner + OW'(1);

    assign arb_owner = r_owner;
    assign arb_busy  = (r_state == BURST);

    // Command path stays combinational; muxes are zeroed when nothing issues.
    always_comb begin
        m_gnt       = '0;
        ddr_addr    = '0;
        ddr_data_in = '0;
        ddr_we      = 1'b0;
        ddr_re      = 1'b0;
        if (w_issue) begin
            ddr_addr       = m_addr[int'(r_owner)*DATA_W +: DATA_W];
            ddr_data_in    = m_wdata[int'(r_owner)*DATA_W +: DATA_W];
            ddr_we         = m_we[r_owner];
            ddr_re         = !m_we[r_owner];
            m_gnt[r_owner] = ddr_ready;
        end
    end

    always_comb begin
        m_rvalid = '0;
        m_rdata  = '0;
        if (r_tag[RD_LAT-1].valid) begin
            m_rvalid[r_tag[RD_LAT-1].id] = 1'b1;
            m_rdata                      = ddr_data_out;
        end
    end

    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            r_state    <= ARB;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            unique case (r_state)
                ARB: begin
                    if (w_any) begin
                        r_owner    <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= BURST;
                    end
                end
                BURST: begin
                    if (w_accept) r_beat_cnt <= r_beat_cnt + CW'(1);
                    if (w_end) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    // Tag pipeline free-runs so reads survive ownership changes.
    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= '{valid: w_accept && !m_we[r_owner],
                          id:    TAG_ID_W'(r_owner)};
            for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: scoreboard bench for ddr_port_arbiter (RD_LAT=3, MAX_BURST=16).
// Compile with DDR_ARB_PCIE_PRIO_EN to check the PCIe-priority build.
module tb_ddr_port_arbiter;

    localparam int NP = 3;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int RL = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   m_req, m_we, m_last, m_gnt, m_rvalid;
    logic [NP*DW-1:0] m_addr, m_wdata;
    logic [DW-1:0]   m_rdata, ddr_addr, ddr_data_in, ddr_data_out;
    logic            ddr_we, ddr_re, ddr_ready, arb_busy;
    logic [1:0]      arb_owner;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        int          cyc;
    } cmd_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } rd_t;

    cmd_t exp_cmd[$];
    rd_t  exp_rd[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          rq_left [NP];
    logic [31:0] rq_addr [NP];
    logic        rq_we   [NP];
    logic        pv [RL];
    logic [31:0] pa [RL];

    ddr_port_arbiter #(
        .N_PORTS(NP), .DATA_W(DW), .MAX_BURST(MB), .RD_LAT(RL)
    ) dut (
        .pcie_clk     (clk),
        .pcie_rst     (rst),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_last       (m_last),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_gnt        (m_gnt),
        .m_rvalid     (m_rvalid),
        .m_rdata      (m_rdata),
        .ddr_addr     (ddr_addr),
        .ddr_data_in  (ddr_data_in),
        .ddr_we       (ddr_we),
        .ddr_re       (ddr_re),
        .ddr_data_out (ddr_data_out),
        .ddr_ready    (ddr_ready),
        .arb_owner    (arb_owner),
        .arb_busy     (arb_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wdat(logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] memv(logic [31:0] a);
        return (a == 32'h0000_2000) ? 32'hDEAD_BEEF : ~a;
    endfunction

    always_comb begin
        m_req   = '0;
        m_we    = '0;
        m_last  = '0;
        m_addr  = '0;
        m_wdata = '0;
        for (int i = 0; i < NP; i++) begin
            m_req[i]             = rq_left[i] > 0;
            m_we[i]              = rq_we[i];
            m_last[i]            = rq_left[i] == 1;
            m_addr[i*DW +: DW]   = rq_addr[i];
            m_wdata[i*DW +: DW]  = wdat(rq_addr[i]);
        end
        ddr_data_out = pv[RL-1] ? memv(pa[RL-1]) : 32'h0;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Requesters advance on grant; memory returns read data RL cycles after accept.
    initial begin
        logic [NP-1:0] g;
        logic          acc;
        logic [31:0]   acc_a;
        forever begin
            @(negedge clk);
            g     = m_gnt;
            acc   = ddr_re && ddr_ready;
            acc_a = ddr_addr;
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (g[i] && rq_left[i] > 0) begin
                    rq_left[i] = rq_left[i] - 1;
                    rq_addr[i] = rq_addr[i] + 32'd4;
                end
            end
            for (int i = RL - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pa[i] = pa[i-1];
            end
            pv[0] = acc;
            pa[0] = acc_a;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && m_gnt != '0) begin
            n_cmp++;
            if (exp_cmd.size() == 0) begin
                n_bad++;
                $display("FAIL cmd: unexpected gnt=%b addr=%h at cyc %0d", m_gnt, ddr_addr, cyc);
            end else begin
                cmd_t          e;
                logic [NP-1:0] eg;
                e  = exp_cmd.pop_front();
                eg = NP'(1) << e.port;
                if (m_gnt !== eg || ddr_we !== e.we || ddr_re !== !e.we ||
                    ddr_addr !== e.addr || ddr_data_in !== wdat(e.addr) || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL cmd: got gnt=%b we=%b re=%b addr=%h wd=%h cyc=%0d, expected gnt=%b we=%b addr=%h wd=%h cyc=%0d",
                             m_gnt, ddr_we, ddr_re, ddr_addr, ddr_data_in, cyc,
                             eg, e.we, e.addr, wdat(e.addr), e.cyc);
                end
                if (!e.we) exp_rd.push_back('{e.port, memv(e.addr), e.cyc + RL});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && m_rvalid != '0) begin
            n_cmp++;
            if (exp_rd.size() == 0) begin
                n_bad++;
                $display("FAIL rd: unexpected rvalid=%b rdata=%h at cyc %0d", m_rvalid, m_rdata, cyc);
            end else begin
                rd_t           r;
                logic [NP-1:0] er;
                r  = exp_rd.pop_front();
                er = NP'(1) << r.port;
                if (m_rvalid !== er || m_rdata !== r.data || cyc != r.cyc) begin
                    n_bad++;
                    $display("FAIL rd: got rvalid=%b rdata=%h cyc=%0d, expected rvalid=%b rdata=%h cyc=%0d",
                             m_rvalid, m_rdata, cyc, er, r.data, r.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input int p, input logic we, input logic [31:0] base, input int n);
        rq_we[p]   = we;
        rq_addr[p] = base;
        rq_left[p] = n;
    endtask

    task automatic push_burst(input int p, input logic we, input logic [31:0] base,
                              input int idx0, input int n, input int c0);
        for (int k = 0; k < n; k++)
            exp_cmd.push_back('{p, we, base + 32'((idx0 + k) * 4), c0 + k});
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((exp_cmd.size() != 0 || exp_rd.size() != 0) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (exp_cmd.size() != 0 || exp_rd.size() != 0) begin
            n_bad++;
            $display("FAIL %s: timeout, %0d cmds and %0d reads outstanding, expected 0",
                     nm, exp_cmd.size(), exp_rd.size());
            exp_cmd.delete();
            exp_rd.delete();
        end
        for (int i = 0; i < NP; i++) rq_left[i] = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        for (int i = 0; i < NP; i++) begin
            rq_left[i] = 0;
            rq_addr[i] = '0;
            rq_we[i]   = 1'b0;
        end
        for (int i = 0; i < RL; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
        end
        ddr_ready = 1'b1;

        @(negedge clk);
        chk("rst_gnt", 32'(m_gnt), 32'h0);
        chk("rst_rvalid", 32'(m_rvalid), 32'h0);
        chk("rst_strobes", 32'({ddr_we, ddr_re, arb_busy}), 32'h0);
        chk("rst_owner", 32'(arb_owner), 32'h0);
        chk("rst_addr", ddr_addr, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Port 1 four-beat write
        t = cyc;
        start(1, 1'b1, 32'h100, 4);
        push_burst(1, 1'b1, 32'h100, 0, 4, t + 1);
        goto(t + 1);
        @(negedge clk);
        chk("w4_busy", 32'(arb_busy), 32'h1);
        chk("w4_owner", 32'(arb_owner), 32'h1);
        goto(t + 5);
        @(negedge clk);
        chk("w4_idle", 32'(arb_busy), 32'h0);
        drain("w4");

        // Port 2 single read, data back after RL cycles
        t = cyc;
        start(2, 1'b0, 32'h2000, 1);
        push_burst(2, 1'b0, 32'h2000, 0, 1, t + 1);
        goto(t + 4);
        @(negedge clk);
        chk("lat_rvalid", 32'(m_rvalid), 32'h4);
        chk("lat_rdata", m_rdata, 32'hDEAD_BEEF);
        drain("lat");

        // Three ports, 20-beat reads each
        t = cyc;
        start(0, 1'b0, 32'h1000, 20);
        start(1, 1'b0, 32'h3000, 20);
        start(2, 1'b0, 32'h5000, 20);
`ifdef DDR_ARB_PCIE_PRIO_EN
        push_burst(0, 1'b0, 32'h1000, 0, 16, t + 1);
        push_burst(0, 1'b0, 32'h1000, 16, 4, t + 18);
        push_burst(1, 1'b0, 32'h3000, 0, 16, t + 23);
        push_burst(2, 1'b0, 32'h5000, 0, 16, t + 40);
        push_burst(1, 1'b0, 32'h3000, 16, 4, t + 57);
        push_burst(2, 1'b0, 32'h5000, 16, 4, t + 62);
`else
        push_burst(0, 1'b0, 32'h1000, 0, 16, t + 1);
        push_burst(1, 1'b0, 32'h3000, 0, 16, t + 18);
        push_burst(2, 1'b0, 32'h5000, 0, 16, t + 35);
        push_burst(0, 1'b0, 32'h1000, 16, 4, t + 52);
        push_burst(1, 1'b0, 32'h3000, 16, 4, t + 57);
        push_burst(2, 1'b0, 32'h5000, 16, 4, t + 62);
`endif
        goto(t + 17);
        @(negedge clk);
        chk("rr_bubble", 32'(m_gnt), 32'h0);
        drain("rr3");

        // Move rr_ptr to 1, then ports 0 and 1 collide
        t = cyc;
        start(0, 1'b1, 32'h40, 1);
        push_burst(0, 1'b1, 32'h40, 0, 1, t + 1);
        drain("ptr1");
        t = cyc;
        start(0, 1'b1, 32'h44, 1);
        start(1, 1'b1, 32'h140, 1);
`ifdef DDR_ARB_PCIE_PRIO_EN
        push_burst(0, 1'b1, 32'h44, 0, 1, t + 1);
        push_burst(1, 1'b1, 32'h140, 0, 1, t + 3);
`else
        push_burst(1, 1'b1, 32'h140, 0, 1, t + 1);
        push_burst(0, 1'b1, 32'h44, 0, 1, t + 3);
`endif
        drain("prio");

        // Port 1 stalled for 5 cycles at beat 5 of an 18-beat write
        t = cyc;
        start(1, 1'b1, 32'h7000, 18);
        push_burst(1, 1'b1, 32'h7000, 0, 4, t + 1);
        push_burst(1, 1'b1, 32'h7000, 4, 12, t + 10);
        push_burst(1, 1'b1, 32'h7000, 16, 2, t + 23);
        goto(t + 5);
        ddr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_gnt", 32'(m_gnt), 32'h0);
            chk("stall_addr", ddr_addr, 32'h7010);
            chk("stall_we", 32'(ddr_we), 32'h1);
            @(posedge clk);
            #1;
        end
        ddr_ready = 1'b1;
        drain("stall");

        // Reset during beat 3 of an 8-beat read with two reads in flight
        t = cyc;
        start(2, 1'b0, 32'h9000, 8);
        push_burst(2, 1'b0, 32'h9000, 0, 8, t + 1);
        goto(t + 3);
        #2;
        rst = 1'b1;
        exp_cmd.delete();
        exp_rd.delete();
        for (int i = 0; i < NP; i++) rq_left[i] = 0;
        #1;
        chk("mid_rst_gnt", 32'(m_gnt), 32'h0);
        chk("mid_rst_strobes", 32'({ddr_we, ddr_re, arb_busy}), 32'h0);
        chk("mid_rst_owner", 32'(arb_owner), 32'h0);
        chk("mid_rst_addr", ddr_addr, 32'h0);
        chk("mid_rst_rvalid", 32'(m_rvalid), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_rvalid", 32'(m_rvalid), 32'h0);
        end
        @(posedge clk);
        #1;
        t = cyc;
        start(1, 1'b0, 32'hA000, 1);
        start(2, 1'b0, 32'hB000, 1);
        push_burst(1, 1'b0, 32'hA000, 0, 1, t + 1);
        push_burst(2, 1'b0, 32'hB000, 0, 1, t + 3);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Round-robin arbiter that shares the single UltraRAM-backed DDR4 command port between the PCIe controller (port 0), the softcore (port 1) and the ML accelerators (port 2). It grants bursts of up to MAX_BURST beats to one owner at a time, forwards that owner's commands to the memory port, and routes returning read data back to the issuing requester by tag.

## Interface
- N_PORTS, 3, number of requesters; port 0 is PCIe.
- DATA_W, 32, data and address width.
- MAX_BURST, 16, maximum beats per grant; must be at least 1.
- RD_LAT, 1, fixed cycles from read accept to ddr_data_out valid; must be at least 1.
- pcie_clk  in  1  single clock; everything is rising-edge.
- pcie_rst  in  1  asynchronous, active-high reset.
- m_req  in  N_PORTS  per-port beat request.
- m_we  in  N_PORTS  1 = write beat, 0 = read beat.
- m_last  in  N_PORTS  final beat of the requester's burst.
- m_addr  in  N_PORTS*DATA_W  per-port byte address; port i is in bits [i*DATA_W +: DATA_W].
- m_wdata  in  N_PORTS*DATA_W  per-port write data.
- m_gnt  out  N_PORTS  beat accepted this cycle.
- m_rvalid  out  N_PORTS  read data valid for port i.
- m_rdata  out  DATA_W  shared read data; qualified by m_rvalid.
- ddr_addr, ddr_data_in  out  DATA_W  command to memory.
- ddr_we, ddr_re  out  1  write or read strobe.
- ddr_data_out  in  DATA_W  read data from memory.
- ddr_ready  in  1  memory accepts the command this cycle.
- arb_owner  out  $clog2(N_PORTS)  current or last burst owner.
- arb_busy  out  1  high in BURST state.

## Operation
- FSM has two states: ARB and BURST. Reset state is ARB.
- In ARB:
  - If any m_req is high, the winner is the first requesting port at or after rr_ptr, searching modulo N_PORTS.
  - Load owner := winner and beat_cnt := 0, then go to BURST. No beat is issued in ARB.
- In BURST, a beat issues when m_req[owner] is high:
  - ddr_we = m_we[owner] and ddr_re = !m_we[owner].
  - ddr_addr and ddr_data_in are muxed from owner.
  - m_gnt[owner] = ddr_ready; every other bit of m_gnt is 0.
- A beat is accepted when it issues and ddr_ready is high. On acceptance, beat_cnt increments.
- The burst ends on the cycle when either of these is true:
  - an accepted beat has m_last high or beat_cnt == MAX_BURST-1; or
  - the owner has m_req low.
- When the burst ends, rr_ptr := owner+1 (mod N_PORTS) and the FSM returns to ARB.
- A stalled beat (ddr_ready low) is held. The requester must keep m_addr, m_wdata, m_we and m_last stable while m_req is high and m_gnt is low.
- Read tag pipeline: RD_LAT stages of {valid, id}. An accepted read pushes {1, owner}; all other beats push {0, x}.
  - At the output stage, m_rvalid[id] = valid and m_rdata = ddr_data_out.
  - The pipeline keeps advancing across ownership changes, so in-flight reads are never lost.
- Address and data pass through unmodified; the arbiter does no width conversion.
- Reset, including mid-burst: state := ARB, rr_ptr := 0, owner := 0, beat_cnt := 0, and all tag-pipeline valid bits are cleared.
  - In-flight reads are dropped.
  - Outputs: m_gnt = 0, m_rvalid = 0, ddr_we = ddr_re = 0, arb_busy = 0, arb_owner = 0.
  - m_rdata, ddr_addr and ddr_data_in are 0 while no beat or valid is active (muxes gated).

## Timing
- Command path is combinational from m_* and ddr_ready to ddr_* and m_gnt. There are no registers on that path.
- Grant latency: a request seen in ARB at cycle t gets its first possible beat at t+1.
- Each ARB step is a one-cycle bubble between bursts. Back-to-back bursts run at MAX_BURST/(MAX_BURST+1) peak efficiency.
- Read data arrives exactly RD_LAT cycles after the accept cycle.
- Starvation bound: a waiting port is granted within (N_PORTS-1)*(MAX_BURST+1) cycles of ARB entries, plus any cycles of ddr_ready low.
- Simultaneous requests: only the round-robin winner is granted. No request is lost; losers simply keep m_req high.

## Configuration
- DDR_ARB_PCIE_PRIO_EN:
  - When defined, at every ARB decision port 0 wins whenever m_req[0] is high, regardless of rr_ptr. Ports 1 to N_PORTS-1 round-robin among themselves.
  - When undefined, all ports are pure round-robin as described above.
  - Burst termination rules are identical in both builds.

## Structure
- Shared package ddr_arb_pkg holds:
  - the state enum {ARB, BURST};
  - port index localparams PORT_PCIE=0, PORT_CORE=1, PORT_ML=2;
  - the tag struct {valid, id}.
- One sub-module, rr_pick: a combinational rotate-priority encoder taking req and ptr and producing the winner index and any. It is reused by the PCIe-priority variant for ports 1 to N_PORTS-1.

## Test plan
- Single port 1 writes 4 beats to 0x100 through 0x10C, last on beat 4, ddr_ready always 1:
  - first beat issues 1 cycle after the request (m_gnt[1] that cycle);
  - 4 beats go out on consecutive cycles, ddr_we high for each, addresses 0x100 through 0x10C;
  - then arb_busy goes low.
- Ports 0, 1 and 2 all request continuous 20-beat reads with MAX_BURST=16:
  - grants are 16 beats to port 0, then port 1, then port 2, each followed by a 1-cycle ARB bubble;
  - then port 0 receives its remaining 4 beats.
- Read latency with RD_LAT=3: port 2 issues a read at cycle t, and memory returns 0xDEADBEEF:
  - m_rvalid[2] is high at t+3 with m_rdata = 0xDEADBEEF;
  - no other m_rvalid bit is asserted.
- Port 1 is mid-burst and ddr_ready is low for 5 cycles:
  - the command is held stable and m_gnt stays 0;
  - beat_cnt is unchanged;
  - the burst resumes when ddr_ready returns.
- With DDR_ARB_PCIE_PRIO_EN defined and rr_ptr=1, ports 0 and 1 request: port 0 is granted first. Without the macro, port 1 is granted first.
- Assert pcie_rst during beat 3 of an 8-beat read with 2 reads in flight:
  - all outputs go to 0 immediately;
  - no m_rvalid appears after release;
  - the next request is granted from rr_ptr=0.
